// File: rtl/lsu_pkg.sv
// Shared types, window defaults and request-decode helpers for the load/store unit.
// The optional LSU_TIMEOUT_EN build adds an ACCESS watchdog in lsu_core_port.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [31:0] BASE_ADDR_DEF  = 32'h8100_0000;
    localparam logic [31:0] LIMIT_ADDR_DEF = 32'h8100_03FC;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } lsu_size_e;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE   = 2'd0;
    localparam lsu_state_t ST_ACCESS = 2'd1;
    localparam lsu_state_t ST_DONE   = 2'd2;

    // Any reason the request must not reach memory: bad code, misalignment, outside window.
    function automatic logic lsu_fault(
        input logic [2:0]  size,
        input logic        we,
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] limit
    );
        logic bad_code;
        logic misalign;
        logic out_win;
        bad_code = 1'b0;
        misalign = 1'b0;
        case (size)
            SZ_B, SZ_BU: misalign = 1'b0;
            SZ_H, SZ_HU: misalign = addr[0];
            SZ_W:        misalign = (addr[1:0] != 2'b00);
            default:     bad_code = 1'b1;
        endcase
        if (we && size[2]) begin
            bad_code = 1'b1;
        end else begin
            bad_code = bad_code;
        end
        out_win = (addr < base) || ({1'b0, addr} > ({1'b0, limit} + 33'd3));
        return bad_code || misalign || out_win;
    endfunction

    function automatic logic [3:0] lsu_byte_en(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [2:0] size, input logic [31:0] wd);
        logic [31:0] rep;
        case (size[1:0])
            2'b00:   rep = {4{wd[7:0]}};
            2'b01:   rep = {2{wd[15:0]}};
            default: rep = wd;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data alignment: selects the addressed lane of the memory word and
// sign- or zero-extends it according to the load size.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rd_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  size_i,
    output logic [31:0] rd_o
);

    logic [31:0] shifted_s;

    always_comb begin
        shifted_s = mem_rd_i >> {off_i, 3'b000};
        case (size_i)
            SZ_B:    rd_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            SZ_BU:   rd_o = {24'd0, shifted_s[7:0]};
            SZ_H:    rd_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            SZ_HU:   rd_o = {16'd0, shifted_s[15:0]};
            default: rd_o = shifted_s;
        endcase
    end

endmodule

// File: rtl/lsu_core_port.sv
// Load/store unit initiator port: checks, issues and completes one core access.
// Define LSU_TIMEOUT_EN to abort an ACCESS that waits TIMEOUT cycles for MEM_READY.
module lsu_core_port
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
    parameter logic [31:0] LIMIT_ADDR = LIMIT_ADDR_DEF
`ifdef LSU_TIMEOUT_EN
    , parameter int unsigned TIMEOUT  = 16
`endif
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        CORE_REQ,
    input  logic        CORE_WE,
    input  logic [2:0]  CORE_SIZE,
    input  logic [31:0] CORE_ADDR,
    input  logic [31:0] CORE_WD,
    output logic [31:0] CORE_RD,
    output logic        STALL,
    output logic        ERR,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_A,
    output logic [31:0] MEM_WD,
    input  logic [31:0] MEM_RD,
    input  logic        MEM_READY
);

    lsu_state_t  state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] rd_q, rd_d;
    logic        err_q, err_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [31:0] mem_wd_q, mem_wd_d;

    logic        fault_s;
    logic        timeout_s;
    logic [31:0] align_s;

    assign fault_s = lsu_fault(CORE_SIZE, CORE_WE, CORE_ADDR, BASE_ADDR, LIMIT_ADDR);

    lsu_load_align u_align (
        .mem_rd_i (MEM_RD),
        .off_i    (off_q),
        .size_i   (size_q),
        .rd_o     (align_s)
    );

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] to_cnt_q, to_cnt_d;

    always_comb begin
        if (state_q == ST_ACCESS) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end else begin
            to_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt_q <= 8'd0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout_s = (state_q == ST_ACCESS) && !MEM_READY && (to_cnt_q == TO_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // MEM_* are loaded only from the captured request, so they stay frozen while waiting.
    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        size_d    = size_q;
        rd_d      = rd_q;
        err_d     = 1'b0;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        mem_be_d  = mem_be_q;
        mem_a_d   = mem_a_q;
        mem_wd_d  = mem_wd_q;
        case (state_q)
            ST_IDLE: begin
                if (CORE_REQ) begin
                    off_d  = CORE_ADDR[1:0];
                    size_d = CORE_SIZE;
                    if (fault_s) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = ST_ACCESS;
                        mem_req_d = 1'b1;
                        mem_we_d  = CORE_WE;
                        mem_be_d  = lsu_byte_en(CORE_SIZE, CORE_ADDR[1:0]);
                        mem_a_d   = {CORE_ADDR[31:2], 2'b00};
                        mem_wd_d  = lsu_wdata(CORE_SIZE, CORE_WD);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (MEM_READY) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'b0000;
                    if (!mem_we_q) begin
                        rd_d = align_s;
                    end else begin
                        rd_d = rd_q;
                    end
                end else if (timeout_s) begin
                    state_d   = ST_DONE;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'b0000;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                mem_be_d  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            off_q     <= 2'b00;
            size_q    <= 3'b000;
            rd_q      <= 32'd0;
            err_q     <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= 4'b0000;
            mem_a_q   <= 32'd0;
            mem_wd_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            size_q    <= size_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            mem_be_q  <= mem_be_d;
            mem_a_q   <= mem_a_d;
            mem_wd_q  <= mem_wd_d;
        end
    end

    assign STALL   = (state_q == ST_IDLE) ? CORE_REQ : (state_q == ST_ACCESS);
    assign CORE_RD = rd_q;
    assign ERR     = err_q;
    assign MEM_REQ = mem_req_q;
    assign MEM_WE  = mem_we_q;
    assign MEM_BE  = mem_be_q;
    assign MEM_A   = mem_a_q;
    assign MEM_WD  = mem_wd_q;

endmodule

// File: tb/tb_lsu_core_port.sv
// Randomized self-checking bench for lsu_core_port against a behavioural access model.
module tb_lsu_core_port;

    localparam logic [31:0] BASE  = 32'h8100_0000;
    localparam logic [31:0] LIMIT = 32'h8100_03FC;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CORE_REQ;
    logic        CORE_WE;
    logic [2:0]  CORE_SIZE;
    logic [31:0] CORE_ADDR;
    logic [31:0] CORE_WD;
    logic [31:0] CORE_RD;
    logic        STALL;
    logic        ERR;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_A;
    logic [31:0] MEM_WD;
    logic [31:0] MEM_RD;
    logic        MEM_READY;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_rd = 32'd0;

    lsu_core_port dut (
        .CLK       (CLK),
        .RST       (RST),
        .CORE_REQ  (CORE_REQ),
        .CORE_WE   (CORE_WE),
        .CORE_SIZE (CORE_SIZE),
        .CORE_ADDR (CORE_ADDR),
        .CORE_WD   (CORE_WD),
        .CORE_RD   (CORE_RD),
        .STALL     (STALL),
        .ERR       (ERR),
        .MEM_REQ   (MEM_REQ),
        .MEM_WE    (MEM_WE),
        .MEM_BE    (MEM_BE),
        .MEM_A     (MEM_A),
        .MEM_WD    (MEM_WD),
        .MEM_RD    (MEM_RD),
        .MEM_READY (MEM_READY)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit mdl_fault(input bit [2:0] sz, input bit we, input bit [31:0] a);
        longint unsigned la;
        la = longint'(a);
        if (!(sz == 3'd0 || sz == 3'd1 || sz == 3'd2 || sz == 3'd4 || sz == 3'd5)) return 1'b1;
        if (we && sz >= 3'd4) return 1'b1;
        if ((sz == 3'd1 || sz == 3'd5) && (a % 2) != 0) return 1'b1;
        if (sz == 3'd2 && (a % 4) != 0) return 1'b1;
        if (la < longint'(BASE) || la > longint'(LIMIT) + 3) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int mdl_nbytes(input bit [2:0] sz);
        if (sz == 3'd0 || sz == 3'd4) return 1;
        if (sz == 3'd1 || sz == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] mdl_be(input bit [2:0] sz, input bit [31:0] a);
        int n;
        n = mdl_nbytes(sz);
        return ((32'd1 << n) - 32'd1) << (a % 4);
    endfunction

    function automatic logic [31:0] mdl_wd(input bit [2:0] sz, input bit [31:0] wd);
        int n;
        n = mdl_nbytes(sz);
        if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] mdl_load(input bit [2:0] sz, input bit [31:0] a, input bit [31:0] word);
        bit [31:0] v;
        v = word >> (8 * (a % 4));
        case (sz)
            3'd0:    return (v & 32'h80) != 0 ? ((v & 32'hFF) | 32'hFFFF_FF00) : (v & 32'hFF);
            3'd4:    return v & 32'hFF;
            3'd1:    return (v & 32'h8000) != 0 ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
            3'd5:    return v & 32'hFFFF;
            default: return v;
        endcase
    endfunction

    // One complete request; lat is the number of ACCESS cycles with MEM_READY low.
    task automatic run_txn(input bit we, input bit [2:0] sz, input bit [31:0] a,
                           input bit [31:0] wd, input bit [31:0] word, input int lat);
        bit flt;
        flt = mdl_fault(sz, we, a);
        @(negedge CLK);
        CORE_REQ  = 1'b1;
        CORE_WE   = we;
        CORE_SIZE = sz;
        CORE_ADDR = a;
        CORE_WD   = wd;
        MEM_RD    = word;
        MEM_READY = 1'b0;
        #1 check_eq("stall_on_req", 32'(STALL), 32'd1);
        @(negedge CLK);
        if (flt) begin
            check_eq("flt_err", 32'(ERR), 32'd1);
            check_eq("flt_stall", 32'(STALL), 32'd0);
            check_eq("flt_memreq", 32'(MEM_REQ), 32'd0);
            check_eq("flt_rd_hold", CORE_RD, model_rd);
        end else begin
            for (int k = 0; k <= lat; k++) begin
                check_eq("acc_req", 32'(MEM_REQ), 32'd1);
                check_eq("acc_stall", 32'(STALL), 32'd1);
                check_eq("acc_err", 32'(ERR), 32'd0);
                check_eq("acc_we", 32'(MEM_WE), 32'(we));
                check_eq("acc_be", 32'(MEM_BE), mdl_be(sz, a));
                check_eq("acc_a", MEM_A, a & 32'hFFFF_FFFC);
                check_eq("acc_wd", MEM_WD, mdl_wd(sz, wd));
                if (k == lat) MEM_READY = 1'b1;
                @(negedge CLK);
            end
            MEM_READY = 1'b0;
            if (!we) model_rd = mdl_load(sz, a, word);
            check_eq("done_stall", 32'(STALL), 32'd0);
            check_eq("done_err", 32'(ERR), 32'd0);
            check_eq("done_memreq", 32'(MEM_REQ), 32'd0);
            check_eq("done_rd", CORE_RD, model_rd);
        end
        CORE_REQ = 1'b0;
        @(negedge CLK);
        check_eq("idle_err", 32'(ERR), 32'd0);
        check_eq("idle_stall", 32'(STALL), 32'd0);
    endtask

    initial begin
        bit [31:0] a;
        bit [2:0]  sz;
        RST       = 1'b1;
        CORE_REQ  = 1'b0;
        CORE_WE   = 1'b0;
        CORE_SIZE = 3'd0;
        CORE_ADDR = 32'd0;
        CORE_WD   = 32'd0;
        MEM_RD    = 32'd0;
        MEM_READY = 1'b0;
        repeat (2) @(negedge CLK);
        check_eq("rst_rd", CORE_RD, 32'd0);
        check_eq("rst_err", 32'(ERR), 32'd0);
        check_eq("rst_memreq", 32'(MEM_REQ), 32'd0);
        check_eq("rst_memwe", 32'(MEM_WE), 32'd0);
        check_eq("rst_be", 32'(MEM_BE), 32'd0);
        check_eq("rst_a", MEM_A, 32'd0);
        check_eq("rst_wd", MEM_WD, 32'd0);
        check_eq("rst_stall", 32'(STALL), 32'd0);
        RST = 1'b0;

        run_txn(1'b0, 3'b010, 32'h8100_0010, 32'd0, 32'hDEAD_BEEF, 0);
        check_eq("lw_val", CORE_RD, 32'hDEAD_BEEF);
        run_txn(1'b0, 3'b000, 32'h8100_0013, 32'd0, 32'h80FF_0000, 1);
        check_eq("lb_val", CORE_RD, 32'hFFFF_FF80);
        run_txn(1'b0, 3'b100, 32'h8100_0013, 32'd0, 32'h80FF_0000, 0);
        check_eq("lbu_val", CORE_RD, 32'h0000_0080);
        run_txn(1'b1, 3'b001, 32'h8100_0006, 32'h1234_ABCD, 32'd0, 0);
        run_txn(1'b0, 3'b010, 32'h8100_0002, 32'd0, 32'h1111_1111, 0);
        run_txn(1'b1, 3'b010, 32'h8000_0000, 32'h5555_5555, 32'd0, 0);
        run_txn(1'b0, 3'b010, 32'h8100_03FC, 32'd0, 32'hCAFE_F00D, 5);
        run_txn(1'b0, 3'b000, 32'h8100_0400, 32'd0, 32'h0, 0);
        run_txn(1'b1, 3'b100, 32'h8100_0000, 32'h0, 32'h0, 0);

        // Reset during a stalled store.
        @(negedge CLK);
        CORE_REQ  = 1'b1;
        CORE_WE   = 1'b1;
        CORE_SIZE = 3'b010;
        CORE_ADDR = 32'h8100_0020;
        CORE_WD   = 32'hA5A5_5A5A;
        @(negedge CLK);
        for (int k = 0; k < 5; k++) begin
            check_eq("wait_req", 32'(MEM_REQ), 32'd1);
            check_eq("wait_stall", 32'(STALL), 32'd1);
            check_eq("wait_a", MEM_A, 32'h8100_0020);
            check_eq("wait_wd", MEM_WD, 32'hA5A5_5A5A);
            @(negedge CLK);
        end
        RST      = 1'b1;
        CORE_REQ = 1'b0;
        @(negedge CLK);
        RST      = 1'b0;
        model_rd = 32'd0;
        check_eq("mid_rst_req", 32'(MEM_REQ), 32'd0);
        check_eq("mid_rst_stall", 32'(STALL), 32'd0);
        check_eq("mid_rst_rd", CORE_RD, 32'd0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = BASE - 32'd16 + 32'($urandom_range(0, 32'h420));
            if ($urandom_range(0, 3) != 0) sz = 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2);
            else sz = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1 && sz != 3'd6) a = a & 32'hFFFF_FFFC;
            run_txn(1'($urandom_range(0, 1)), sz, a, $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
